// File: rtl/panel_sequencer_pkg.sv
// panel_sequencer_pkg: shared state encoding, request indices and priority helpers
package panel_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_EXT, S_LOAD, S_DEP_REQ, S_EXAM_REQ, S_INC, S_CONT
  } state_t;
  localparam int N_REQ = 6;
  localparam int R_CLR = 0;
  localparam int R_EXT = 1;
  localparam int R_LOAD = 2;
  localparam int R_DEP = 3;
  localparam int R_EXAM = 4;
  localparam int R_CONT = 5;
  localparam logic [N_REQ-1:0] ANY_TIME = N_REQ'(1) << R_CLR;
  function automatic logic [N_REQ-1:0] pick(input logic [N_REQ-1:0] p);
    return p & (-p);
  endfunction
  function automatic state_t req_state(input logic [N_REQ-1:0] g);
    return g[R_CLR] ? S_CLR : g[R_EXT] ? S_EXT : g[R_LOAD] ? S_LOAD :
           g[R_DEP] ? S_DEP_REQ : g[R_EXAM] ? S_EXAM_REQ : g[R_CONT] ? S_CONT : S_IDLE;
  endfunction
endpackage

// File: rtl/panel_sequencer_req_latch.sv
// panel_req_latch: sticky panel request capture, halted qualification and priority grant
module panel_req_latch
  import panel_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] pulse,
  input  logic             halted,
  input  logic [N_REQ-1:0] take,
  output logic [N_REQ-1:0] pend,
  output logic [N_REQ-1:0] grant
);
  logic [N_REQ-1:0] acc;
  always_comb acc = pulse & ~pend & (halted ? {N_REQ{1'b1}} : ANY_TIME);
  assign grant = pick(pend);
  always_ff @(posedge clk or negedge reset)
    if (!reset) pend <= '0;
    else pend <= (pend & ~take) | acc;
endmodule

// File: rtl/panel_sequencer.sv
// panel_sequencer: front-panel command sequencer driving memory cycles and cpu control pulses
module panel_sequencer
  import panel_sequencer_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cleard,
  input  logic        extd_addrd,
  input  logic        addr_loadd,
  input  logic        depd,
  input  logic        examd,
  input  logic        contd,
  input  logic        halted,
  input  logic [11:0] sr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [11:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [11:0] mem_rdata,
  output logic [11:0] ma,
  output logic [11:0] md,
  output logic [2:0]  ifld,
  output logic [2:0]  dfld,
  output logic        cpu_clear,
  output logic        cpu_cont,
  output logic        busy,
  output logic        err
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [N_REQ-1:0] pend, grant, take;
  assign take = (state == S_IDLE) ? grant : '0;
  panel_req_latch u_latch (
    .clk(clk), .reset(reset),
    .pulse({contd, examd, depd, addr_loadd, extd_addrd, cleard}),
    .halted(halted), .take(take), .pend(pend), .grant(grant)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      ma <= '0;
      md <= '0;
      ifld <= '0;
      dfld <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cpu_clear <= 1'b0;
      cpu_cont <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= req_state(grant);
          busy <= |grant;
          cpu_clear <= grant[R_CLR];
          cpu_cont <= 1'b0;
          cnt <= '0;
          if (grant[R_CLR]) err <= 1'b0;
          mem_req <= grant[R_DEP] | grant[R_EXAM];
          mem_we <= grant[R_DEP];
          mem_addr <= {ifld, ma};
          mem_wdata <= grant[R_DEP] ? sr : mem_wdata;
        end
        S_CLR: begin
          cpu_clear <= 1'b0;
          state <= S_IDLE;
          busy <= 1'b0;
        end
        S_EXT: begin
          ifld <= sr[5:3];
          dfld <= sr[2:0];
          state <= S_IDLE;
          busy <= 1'b0;
        end
        S_LOAD: begin
          ma <= sr;
          state <= S_IDLE;
          busy <= 1'b0;
        end
        S_DEP_REQ, S_EXAM_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            md <= (state == S_DEP_REQ) ? sr : mem_rdata;
            state <= S_INC;
          end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            err <= 1'b1;
            state <= S_IDLE;
            busy <= 1'b0;
          end else cnt <= cnt + CW'(1);
        end
        S_INC: begin
          ma <= ma + 12'd1;
          state <= S_IDLE;
          busy <= 1'b0;
        end
        S_CONT: begin
          cpu_cont <= halted;
          state <= S_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule
